// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver FSM encoding, data width, counter-width helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    // Bits needed to hold 0..depth-1, never less than one.
    function automatic int uart_clog2_cnt(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head output, valid/ready pop and overrun pulse; shared by UART RX and TX.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [DATA_W-1:0]       push_data_i,
    input  logic                    ready_i,
    output logic [DATA_W-1:0]       head_o,
    output logic                    valid_o,
    output logic                    overrun_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  count_after_pop;
    logic [DATA_W-1:0] head_q, head_d;
    logic              overrun_q, overrun_d;
    logic              full;
    logic              pop;
    logic              wr_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign pop   = ready_i && (count_q != '0);
    assign wr_en = push_i && (!full || pop);

    always_comb begin
        rd_ptr_d        = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d        = wr_ptr_q + PTR_W'(wr_en);
        count_d         = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        count_after_pop = count_q - CNT_W'(pop);
        overrun_d       = push_i && full && !pop;
        // A byte pushed into an empty FIFO bypasses the array so it is at the head next cycle.
        if (count_after_pop != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (wr_en) begin
            head_d = push_data_i;
        end else begin
            head_d = head_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            overrun_q <= overrun_d;
        end
    end

    assign head_o    = head_q;
    assign valid_o   = (count_q != '0);
    assign overrun_o = overrun_q;
    assign count_o   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART0 receiver: 8N1 deserialiser (8E1 with UART_RX_PARITY_EN defined) feeding a valid/ready byte FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          rx_i,
    output logic [UART_DATA_BITS-1:0]     rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    output logic                          rx_busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                          parity_err_o
`endif
);

    localparam int CNT_W = uart_clog2_cnt(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    uart_rx_state_t            state_q, state_d;
    logic                      sync1_q, sync2_q;
    logic                      rx_s;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q;
    logic [UART_DATA_BITS-1:0] shreg_q;
    logic                      cnt_at_half;
    logic                      cnt_at_bit;
    logic                      stop_sample;
    logic                      par_err;
    logic                      push;
    logic                      frame_err_q, frame_err_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s        = sync2_q;
    assign cnt_at_half = (cnt_q == HALF_LAST);
    assign cnt_at_bit  = (cnt_q == BIT_LAST);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint was only a glitch.
                if (cnt_at_half) begin
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_at_bit && (idx_q == IDX_W'(UART_DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_at_bit) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_at_bit) begin
                    state_d = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The bit timer restarts on every state entry and free-runs within DATA.
    always_comb begin
        if ((state_d != state_q) || (state_q == IDLE) || cnt_at_bit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == START) begin
                idx_q <= '0;
            end else if ((state_q == DATA) && cnt_at_bit) begin
                shreg_q[idx_q] <= rx_s;
                idx_q          <= idx_q + 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err_q;
    logic parity_err_q, parity_err_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            par_err_q <= 1'b0;
        end else if (state_q == IDLE) begin
            par_err_q <= 1'b0;
        end else if ((state_q == PARITY) && cnt_at_bit) begin
            // Even parity: the parity bit equals the XOR of the data bits.
            par_err_q <= rx_s ^ (^shreg_q);
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        stop_sample = (state_q == STOP) && cnt_at_bit;
        push        = stop_sample && rx_s && !par_err;
        frame_err_d = stop_sample && (!rx_s || par_err);
`ifdef UART_RX_PARITY_EN
        parity_err_d = stop_sample && rx_s && par_err;
`endif
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err_o = parity_err_q;
`endif

    assign frame_err_o = frame_err_q;
    assign rx_busy_o   = (state_q != IDLE);

    sync_fifo #(
        .DATA_W (UART_DATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (reset_ni),
        .push_i      (push),
        .push_data_i (shreg_q),
        .ready_i     (rx_ready_i),
        .head_o      (rx_data_o),
        .valid_o     (rx_valid_o),
        .overrun_o   (overrun_o),
        .count_o     (fifo_count_o)
    );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive side of the SoC UART0 serial link; the bench or an external host drives the serial line, and this block deserialises it.
- Samples the serial rx line, decodes 8N1 frames (LSB first), and buffers received bytes in a small FIFO.
- The FIFO is exposed to the peripheral bus logic through a valid/ready stream.
- Sits inside the UART0 peripheral, next to the existing transmitter; its rx pin comes from the SoC peripheral interface.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- rx_i  in  1  serial input, idle high, asynchronous to clk_i
- rx_data_o  out  8  head-of-FIFO byte
- rx_valid_o  out  1  FIFO not empty
- rx_ready_i  in  1  consumer accepts rx_data_o when rx_valid_o && rx_ready_i
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overrun_o  out  1  one-cycle pulse: byte dropped because the FIFO was full
- rx_busy_o  out  1  high whenever FSM is not IDLE
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
Reset:
- Asynchronous assert, synchronous deassert handled at SoC level.
- Synchroniser flops reset to 1.
- FSM goes to IDLE; FIFO is emptied.
- All outputs reset to 0 (rx_data_o = 8'h00).
- Reset mid-frame discards the partial byte; after release the block waits for a fresh falling edge.

Synchroniser:
- 2-flop synchroniser on rx_i; all decisions use the synchronised value.
- Input-to-decision latency is 2 cycles.

Bit counter:
- Counts 0..CLKS_PER_BIT-1 and reloads on each state entry.

FSM:
- IDLE: on synchronised rx == 0, go to START and clear the counter.
- START: at count CLKS_PER_BIT/2-1, resample.
  - Low: go to DATA and clear bit index and counter.
  - High: treat as a glitch and return to IDLE; no error is flagged.
- DATA: each time the counter reaches CLKS_PER_BIT-1 (mid-bit), shift the sample into bit [idx] (LSB first).
  - After idx 7, go to PARITY if UART_RX_PARITY_EN is defined, otherwise go to STOP.
- PARITY (optional): at mid-bit, compare the sample with the even parity of the data and latch a mismatch; then go to STOP.
- STOP: at mid-bit:
  - Sample == 1 and no parity error: push the byte and go to IDLE.
  - Sample == 0: pulse frame_err_o, drop the byte, go to BREAK.
  - Parity error: see Optional Feature.
- BREAK: wait for synchronised rx == 1, then go to IDLE. A held-low line yields exactly one frame_err_o.

FIFO:
- Push happens in the stop-bit sample cycle; rx_valid_o rises the following cycle.
- rx_data_o is registered from the FIFO head and is stable while rx_valid_o && !rx_ready_i.
- Pop on rx_valid_o && rx_ready_i.
- Push when full with no pop: byte dropped, overrun_o pulses, contents unchanged.
- Push and pop in the same cycle when full: both take effect, no overrun, count unchanged.
- Push and pop in the same cycle when empty: the push is not visible until the next cycle; no pop occurs.
- Pointers wrap modulo FIFO_DEPTH; count saturates at FIFO_DEPTH, with an extra bit distinguishing full from empty.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frames are 8E1 and the PARITY state is included.
  - Parity mismatch (with a valid stop bit) drops the byte and pulses frame_err_o.
  - Add output port parity_err_o (1 bit, one-cycle pulse, reset 0), which pulses together with frame_err_o.
- Undefined:
  - Frames are 8N1; no PARITY state and no parity_err_o port.

Decomposition:
- uart_pkg:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - localparam UART_DATA_BITS = 8.
  - Function uart_clog2_cnt(depth) for counter widths.
- Sub-module sync_fifo (DATA_W, DEPTH): reusable by the transmitter; holds the push/pop/full/empty/count logic.
- The FSM and bit counter stay in uart_rx_fifo.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4, rx_ready_i=1 unless noted):
- Single frame: send 0xA5 (8N1) → rx_valid_o one cycle after stop-bit mid-sample, rx_data_o=0xA5, fifo_count_o returns to 0 after the pop, no error pulses.
- Glitch rejection: drive rx_i low for 5 cycles in IDLE, then high → FSM returns to IDLE, no byte, no frame_err_o.
- Framing error: send 0x3C with the stop bit low, holding low for 40 cycles → exactly one frame_err_o pulse, nothing pushed, rx_busy_o low only after the line rises.
- Overrun: rx_ready_i=0, send 0x01..0x05 → count=4, one overrun_o pulse on byte 0x05; then raise rx_ready_i → reads 0x01,0x02,0x03,0x04 in order.
- Full push+pop: FIFO full, pulse rx_ready_i exactly in the push cycle of 0x77 → no overrun_o, count stays 4, 0x77 becomes the last entry.
- Reset mid-frame: assert reset_ni low during DATA bit 4 of 0xFF → all outputs 0 during reset; after release the next frame 0x5A is received correctly. With UART_RX_PARITY_EN, additionally send 0x07 with wrong parity → parity_err_o and frame_err_o pulse, no byte.
